// File: rtl/player_core_if.sv
// Command/status bundle between the game-flow controller (master) and the
// player core (slave): instruction word, strobes, and the player's state.
interface player_core_if;
   logic [15:0] playerInstruction;
   logic        isMove;
   logic        startDmg;
   logic [7:0]  hp;
   logic [9:0]  posX;
   logic [9:0]  posY;
   logic        isDeath;
   logic        dmgAck;
   logic        invuln;

   modport master (
      output playerInstruction, isMove, startDmg,
      input  hp, posX, posY, isDeath, dmgAck, invuln
   );

   modport slave (
      input  playerInstruction, isMove, startDmg,
      output hp, posX, posY, isDeath, dmgAck, invuln
   );
endinterface

// File: rtl/player_core.sv
// Player state engine: HP, arena position, invulnerability window and death
// flag, driven by the controller's instruction word and move/damage strobes.
module player_core #(
   parameter int HP_MAX   = 100,
   parameter int X_INIT   = 320,
   parameter int Y_INIT   = 360,
   parameter int X_MIN    = 220,
   parameter int X_MAX    = 420,
   parameter int Y_MIN    = 260,
   parameter int Y_MAX    = 460,
   parameter int STEP     = 2,
   parameter int MOVE_DIV = 4,
   parameter int IFRAMES  = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   player_core_if.slave bus
);

   typedef enum logic [1:0] {IDLE, APPLY, IFRAME, DEAD} state_t;

   localparam logic [3:0]  OP_HPY = 4'd1;
   localparam logic [3:0]  OP_DPY = 4'd2;
   localparam logic [3:0]  OP_IDG = 4'd3;
   localparam logic [3:0]  OP_SDG = 4'd4;
   localparam logic [3:0]  OP_MOV = 4'd5;
   localparam logic [3:0]  OP_SHP = 4'd6;

   localparam logic [7:0]  HP_CAP    = 8'(HP_MAX);
   localparam logic [9:0]  X0        = 10'(X_INIT);
   localparam logic [9:0]  Y0        = 10'(Y_INIT);
   localparam logic [10:0] XL        = 11'(X_MIN);
   localparam logic [10:0] XH        = 11'(X_MAX);
   localparam logic [10:0] YL        = 11'(Y_MIN);
   localparam logic [10:0] YH        = 11'(Y_MAX);
   localparam logic [10:0] STP       = 11'(STEP);
   localparam logic [7:0]  IFR_LOAD  = 8'(IFRAMES);
   localparam logic [7:0]  MOVE_LOAD = 8'(MOVE_DIV - 1);

   state_t      state;
   state_t      ret_state;
   logic [7:0]  hp_q;
   logic [9:0]  pos_x;
   logic [9:0]  pos_y;
   logic        is_death;
   logic        dmg_ack;
   logic        invuln_q;
   logic        lat_heal;
   logic [7:0]  lat_val;
   logic [7:0]  ifr_cnt;
   logic [7:0]  move_cnt;
   logic        force_inv;
   logic [15:0] instr_prev;

   logic [3:0]  opcode;
   logic [7:0]  operand;
   logic        word_change;
   logic        shp_cmd;
   logic        idg_cmd;
   logic        sdg_cmd;
   logic        start_ok;
   logic        move_ok;
   logic        ifr_expire;
   logic [7:0]  shp_hp;

   assign opcode      = bus.playerInstruction[15:12];
   assign operand     = bus.playerInstruction[11:4];
   assign word_change = (bus.playerInstruction != instr_prev);
   assign shp_cmd     = word_change && (opcode == OP_SHP);
   assign idg_cmd     = word_change && (opcode == OP_IDG);
   assign sdg_cmd     = word_change && (opcode == OP_SDG);
   assign start_ok    = bus.startDmg && ((opcode == OP_HPY) || (opcode == OP_DPY)) &&
                        ((state == IDLE) || (state == IFRAME));
   assign move_ok     = bus.isMove && (opcode == OP_MOV) && (move_cnt == 8'd0) && (state != DEAD);
   assign ifr_expire  = (ifr_cnt <= 8'd1);
   assign shp_hp      = (operand > HP_CAP) ? HP_CAP : operand;

   // Result of the latched heal/damage request, consumed in APPLY.
   logic [8:0]  heal_sum;
   logic [7:0]  apply_hp;
   logic        apply_hit;
   logic        apply_dead;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      heal_sum  = {1'b0, hp_q} + {1'b0, lat_val};
      apply_hp  = hp_q;
      apply_hit = 1'b0;
      if (lat_heal) begin
         apply_hp = (heal_sum > {1'b0, HP_CAP}) ? HP_CAP : heal_sum[7:0];
      end else if (!invuln_q) begin
         apply_hit = 1'b1;
         apply_hp  = (lat_val >= hp_q) ? 8'd0 : hp_q - lat_val;
      end
      apply_dead = (apply_hp == 8'd0);
   end

   logic [10:0] x_ext;
   logic [10:0] y_ext;
   logic [9:0]  next_x;
   logic [9:0]  next_y;

   always_comb begin
      x_ext  = {1'b0, pos_x};
      y_ext  = {1'b0, pos_y};
      next_x = pos_x;
      next_y = pos_y;
      case (operand[1:0])
         2'd0: next_y = (y_ext < YL + STP) ? 10'(YL) : 10'(y_ext - STP);
         2'd1: next_x = (x_ext < XL + STP) ? 10'(XL) : 10'(x_ext - STP);
         2'd2: next_y = (y_ext + STP > YH) ? 10'(YH) : 10'(y_ext + STP);
         default: next_x = (x_ext + STP > XH) ? 10'(XH) : 10'(x_ext + STP);
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments; later writes in
   // this block deliberately override earlier ones (SHP > IDG/SDG > FSM).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ret_state  <= IDLE;
         hp_q       <= HP_CAP;
         pos_x      <= X0;
         pos_y      <= Y0;
         is_death   <= 1'b0;
         dmg_ack    <= 1'b0;
         invuln_q   <= 1'b0;
         lat_heal   <= 1'b0;
         lat_val    <= 8'd0;
         ifr_cnt    <= 8'd0;
         move_cnt   <= 8'd0;
         force_inv  <= 1'b0;
         instr_prev <= 16'd0;
      end else begin
         instr_prev <= bus.playerInstruction;
         dmg_ack    <= 1'b0;

         if (move_ok) begin
            pos_x    <= next_x;
            pos_y    <= next_y;
            move_cnt <= MOVE_LOAD;
         end else if (move_cnt != 8'd0) begin
            move_cnt <= move_cnt - 8'd1;
         end

         if (shp_cmd) begin
            hp_q      <= shp_hp;
            pos_x     <= X0;
            pos_y     <= Y0;
            ifr_cnt   <= 8'd0;
            force_inv <= 1'b0;
            invuln_q  <= 1'b0;
            is_death  <= (operand == 8'd0);
            state     <= (operand == 8'd0) ? DEAD : IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start_ok) begin
                     lat_heal  <= (opcode == OP_HPY);
                     lat_val   <= operand;
                     ret_state <= IDLE;
                     state     <= APPLY;
                  end
               end
               IFRAME: begin
                  ifr_cnt <= ifr_expire ? 8'd0 : ifr_cnt - 8'd1;
                  if (ifr_expire) invuln_q <= force_inv;
                  if (start_ok) begin
                     lat_heal  <= (opcode == OP_HPY);
                     lat_val   <= operand;
                     ret_state <= ifr_expire ? IDLE : IFRAME;
                     state     <= APPLY;
                  end else if (ifr_expire) begin
                     state <= IDLE;
                  end
               end
               APPLY: begin
                  hp_q    <= apply_hp;
                  dmg_ack <= 1'b1;
                  if (apply_dead) begin
                     is_death <= 1'b1;
                     ifr_cnt  <= 8'd0;
                     invuln_q <= force_inv;
                     state    <= DEAD;
                  end else if (apply_hit) begin
                     invuln_q <= 1'b1;
                     ifr_cnt  <= IFR_LOAD;
                     state    <= IFRAME;
                  end else if (ret_state == IFRAME) begin
                     // Window keeps counting down through the APPLY cycle.
                     ifr_cnt <= ifr_expire ? 8'd0 : ifr_cnt - 8'd1;
                     if (ifr_expire) invuln_q <= force_inv;
                     state <= ifr_expire ? IDLE : IFRAME;
                  end else begin
                     state <= IDLE;
                  end
               end
               DEAD: begin
               end
            endcase

            if (idg_cmd) begin
               force_inv <= 1'b1;
               invuln_q  <= 1'b1;
            end
            if (sdg_cmd) begin
               force_inv <= 1'b0;
               ifr_cnt   <= 8'd0;
               invuln_q  <= 1'b0;
               if ((state != DEAD) && !((state == APPLY) && apply_dead)) state <= IDLE;
            end
         end
      end
   end

   assign bus.hp      = hp_q;
   assign bus.posX    = pos_x;
   assign bus.posY    = pos_y;
   assign bus.isDeath = is_death;
   assign bus.dmgAck  = dmg_ack;
   assign bus.invuln  = invuln_q;

endmodule

// File: tb/tb_player_core.sv
// Bench for player_core: directed vector table, multi-cycle corner sequences,
// and random traffic compared against an event/time-based reference model.
module tb_player_core;
   localparam int HP_MAX   = 100;
   localparam int X_INIT   = 320;
   localparam int Y_INIT   = 360;
   localparam int X_MIN    = 220;
   localparam int X_MAX    = 420;
   localparam int Y_MIN    = 260;
   localparam int Y_MAX    = 460;
   localparam int STEP     = 2;
   localparam int MOVE_DIV = 4;
   localparam int IFRAMES  = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   player_core_if bus ();

   player_core #(
      .HP_MAX(HP_MAX), .X_INIT(X_INIT), .Y_INIT(Y_INIT),
      .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
      .STEP(STEP), .MOVE_DIV(MOVE_DIV), .IFRAMES(IFRAMES)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference model: request queue of depth one, invulnerability as an
   // absolute end-edge, move pacing as the next edge a move may happen.
   int          m_hp, m_x, m_y, m_win_end, m_next_move, m_edge, m_pend_op, m_pend_val;
   bit          m_dead, m_force, m_ack, m_inv, m_pend;
   logic [15:0] m_prev;

   task automatic model_reset();
      m_hp = HP_MAX; m_x = X_INIT; m_y = Y_INIT;
      m_win_end = 0; m_next_move = 0; m_edge = 0;
      m_dead = 0; m_force = 0; m_ack = 0; m_inv = 0; m_pend = 0;
      m_pend_op = 0; m_pend_val = 0; m_prev = 16'h0000;
   endtask

   task automatic model_edge(input logic [15:0] ins, input bit mv, input bit sd);
      int op, v;
      bit wc, was_dead, old_inv;
      op = int'(ins[15:12]);
      v  = int'(ins[11:4]);
      wc = (ins != m_prev);
      was_dead = m_dead;
      old_inv  = m_inv;
      m_edge++;
      m_prev = ins;
      m_ack  = 0;
      if (wc && op == 6) begin
         m_hp = (v > HP_MAX) ? HP_MAX : v;
         m_x = X_INIT; m_y = Y_INIT;
         m_force = 0; m_win_end = 0; m_pend = 0;
         m_dead = (m_hp == 0);
      end else begin
         if (m_pend) begin
            m_pend = 0;
            m_ack  = 1;
            if (m_pend_op == 1) begin
               m_hp = (m_hp + m_pend_val > HP_MAX) ? HP_MAX : m_hp + m_pend_val;
            end else if (!old_inv) begin
               m_hp = (m_pend_val >= m_hp) ? 0 : m_hp - m_pend_val;
               if (m_hp != 0) m_win_end = m_edge + IFRAMES;
            end
            if (m_hp == 0) m_dead = 1;
         end else if (sd && (op == 1 || op == 2) && !was_dead) begin
            m_pend = 1; m_pend_op = op; m_pend_val = v;
         end
         if (wc && op == 3) m_force = 1;
         if (wc && op == 4) begin m_force = 0; m_win_end = 0; end
      end
      if (mv && op == 5 && m_edge >= m_next_move && !was_dead) begin
         m_next_move = m_edge + MOVE_DIV;
         case (v % 4)
            0: m_y = (m_y - STEP < Y_MIN) ? Y_MIN : m_y - STEP;
            1: m_x = (m_x - STEP < X_MIN) ? X_MIN : m_x - STEP;
            2: m_y = (m_y + STEP > Y_MAX) ? Y_MAX : m_y + STEP;
            default: m_x = (m_x + STEP > X_MAX) ? X_MAX : m_x + STEP;
         endcase
      end
      m_inv = m_force || (m_edge < m_win_end);
   endtask

   task automatic compare_model();
      check("model_hp",     int'(bus.hp),      m_hp);
      check("model_posX",   int'(bus.posX),    m_x);
      check("model_posY",   int'(bus.posY),    m_y);
      check("model_isDeath", int'(bus.isDeath), int'(m_dead));
      check("model_dmgAck", int'(bus.dmgAck),  int'(m_ack));
      check("model_invuln", int'(bus.invuln),  int'(m_inv));
   endtask

   task automatic drive_edge(input logic [15:0] ins, input bit mv, input bit sd);
      @(negedge clk);
      bus.playerInstruction = ins;
      bus.isMove   = mv;
      bus.startDmg = sd;
      @(posedge clk);
      #1;
      model_edge(ins, mv, sd);
      compare_model();
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      bus.playerInstruction = 16'h0000;
      bus.isMove   = 1'b0;
      bus.startDmg = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   typedef struct {
      logic [15:0] ins;
      bit          mv;
      bit          sd;
      int          hp;
      int          x;
      int          y;
      bit          death;
      bit          ack;
      bit          inv;
   } vec_t;

   vec_t        vecs [19];
   logic [15:0] rins;
   int          rop, rval;

   initial begin
      // Directed walk: damage, iframe, heal, death, dead-state immunity, respawn.
      vecs[0]  = '{16'h0000, 1'b0, 1'b0, 100, 320, 360, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{16'h21E0, 1'b0, 1'b1, 100, 320, 360, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{16'h21E0, 1'b0, 1'b0,  70, 320, 360, 1'b0, 1'b1, 1'b1};
      vecs[3]  = '{16'h21E0, 1'b0, 1'b0,  70, 320, 360, 1'b0, 1'b0, 1'b1};
      vecs[4]  = '{16'h21E0, 1'b0, 1'b1,  70, 320, 360, 1'b0, 1'b0, 1'b1};
      vecs[5]  = '{16'h21E0, 1'b0, 1'b0,  70, 320, 360, 1'b0, 1'b1, 1'b1};
      vecs[6]  = '{16'h21E0, 1'b0, 1'b0,  70, 320, 360, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{16'h21E0, 1'b0, 1'b0,  70, 320, 360, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{16'h21E0, 1'b0, 1'b0,  70, 320, 360, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{16'h21E0, 1'b0, 1'b0,  70, 320, 360, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{16'h21E0, 1'b0, 1'b0,  70, 320, 360, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{16'h1320, 1'b0, 1'b1,  70, 320, 360, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{16'h1320, 1'b0, 1'b0, 100, 320, 360, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{16'h2780, 1'b0, 1'b1, 100, 320, 360, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{16'h2780, 1'b0, 1'b0,   0, 320, 360, 1'b1, 1'b1, 1'b0};
      vecs[15] = '{16'h5030, 1'b1, 1'b1,   0, 320, 360, 1'b1, 1'b0, 1'b0};
      vecs[16] = '{16'h2780, 1'b0, 1'b1,   0, 320, 360, 1'b1, 1'b0, 1'b0};
      vecs[17] = '{16'h2780, 1'b0, 1'b0,   0, 320, 360, 1'b1, 1'b0, 1'b0};
      vecs[18] = '{16'h6640, 1'b0, 1'b0, 100, 320, 360, 1'b0, 1'b0, 1'b0};

      reset_dut();
      check("reset_hp",      int'(bus.hp),      100);
      check("reset_posX",    int'(bus.posX),    320);
      check("reset_posY",    int'(bus.posY),    360);
      check("reset_isDeath", int'(bus.isDeath), 0);
      check("reset_dmgAck",  int'(bus.dmgAck),  0);
      check("reset_invuln",  int'(bus.invuln),  0);

      for (int i = 0; i < 19; i++) begin
         drive_edge(vecs[i].ins, vecs[i].mv, vecs[i].sd);
         check($sformatf("vec%0d_hp", i),     int'(bus.hp),      vecs[i].hp);
         check($sformatf("vec%0d_posX", i),   int'(bus.posX),    vecs[i].x);
         check($sformatf("vec%0d_posY", i),   int'(bus.posY),    vecs[i].y);
         check($sformatf("vec%0d_death", i),  int'(bus.isDeath), int'(vecs[i].death));
         check($sformatf("vec%0d_ack", i),    int'(bus.dmgAck),  int'(vecs[i].ack));
         check($sformatf("vec%0d_invuln", i), int'(bus.invuln),  int'(vecs[i].inv));
      end

      // Held move right: one step every MOVE_DIV cycles, then clamp at the wall.
      for (int k = 0; k < 20; k++) begin
         drive_edge(16'h5030, 1'b1, 1'b0);
         check($sformatf("move_right_%0d", k), int'(bus.posX), 320 + 2 * (k / 4 + 1));
      end
      repeat (200) drive_edge(16'h5030, 1'b1, 1'b0);
      check("wall_x_max", int'(bus.posX), 420);
      repeat (300) drive_edge(16'h5000, 1'b1, 1'b0);
      check("wall_y_min", int'(bus.posY), 260);

      // Forced invulnerability, then released.
      drive_edge(16'h3000, 1'b0, 1'b0);
      check("idg_invuln", int'(bus.invuln), 1);
      drive_edge(16'h2320, 1'b0, 1'b1);
      drive_edge(16'h2320, 1'b0, 1'b0);
      check("idg_dmg_hp", int'(bus.hp), 100);
      check("idg_dmg_ack", int'(bus.dmgAck), 1);
      drive_edge(16'h4000, 1'b0, 1'b0);
      check("sdg_invuln", int'(bus.invuln), 0);
      drive_edge(16'h2320, 1'b0, 1'b1);
      drive_edge(16'h2320, 1'b0, 1'b0);
      check("sdg_dmg_hp", int'(bus.hp), 50);
      check("sdg_dmg_ack", int'(bus.dmgAck), 1);

      // Reset arriving while a request sits in APPLY aborts it.
      reset_dut();
      drive_edge(16'h63C0, 1'b0, 1'b0);
      check("shp60_hp", int'(bus.hp), 60);
      drive_edge(16'h20A0, 1'b0, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      bus.playerInstruction = 16'h0000;
      bus.startDmg = 1'b0;
      #1;
      check("rst_abort_hp", int'(bus.hp), 100);
      @(posedge clk);
      #1;
      check("rst_abort_ack", int'(bus.dmgAck), 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      drive_edge(16'h0000, 1'b0, 1'b0);
      check("rst_abort_ack_after", int'(bus.dmgAck), 0);

      // SHP word change while a request is in APPLY: SHP wins, no ack.
      drive_edge(16'h20A0, 1'b0, 1'b1);
      drive_edge(16'h6500, 1'b0, 1'b0);
      check("shp_preempt_hp", int'(bus.hp), 80);
      check("shp_preempt_ack", int'(bus.dmgAck), 0);
      drive_edge(16'h6500, 1'b0, 1'b0);
      check("shp_preempt_ack2", int'(bus.dmgAck), 0);

      // Random traffic against the model.
      rins = 16'h0000;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            rop = int'($urandom_range(0, 8));
            if (rop == 6 && $urandom_range(0, 3) != 0) rop = 2;
            if ($urandom_range(0, 1) == 1) rval = int'($urandom_range(0, 40));
            else rval = int'($urandom_range(0, 255));
            rins = {rop[3:0], rval[7:0], 4'($urandom_range(0, 15))};
         end
         drive_edge(rins, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/player_core.md
# player_core

Executes the 16-bit player instruction word and strobes driven by the game-flow controller. Maintains the player's HP, arena position, invulnerability window and death flag, and acknowledges each damage/heal request. Sits between the game-flow controller and the renderer/collision logic. It is the responder end of the `playerInstruction` / `isMove` / `startDmg` interface.

## Interface
Parameters:
- `HP_MAX`, 100: HP ceiling and reset HP.
- `X_INIT`, 320: reset/spawn X.
- `Y_INIT`, 360: reset/spawn Y.
- `X_MIN`, 220: X clamp, lower bound.
- `X_MAX`, 420: X clamp, upper bound.
- `Y_MIN`, 260: Y clamp, lower bound.
- `Y_MAX`, 460: Y clamp, upper bound.
- `STEP`, 2: pixels per accepted move.
- `MOVE_DIV`, 4: minimum cycles between accepted moves (≥1).
- `IFRAMES`, 8: invulnerability cycles after an applied damage.

Ports:
- `clk` in 1: system clock; everything is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `playerInstruction` in 16: [15:12] opcode, [11:4] operand, [3:0] ignored.
- `isMove` in 1: move strobe.
- `startDmg` in 1: damage/heal strobe, one cycle.
- `hp` out 8: current HP.
- `posX` out 10: player X.
- `posY` out 10: player Y.
- `isDeath` out 1: level, high while HP is 0.
- `dmgAck` out 1: one-cycle completion pulse for a `startDmg`.
- `invuln` out 1: high while damage is being ignored.

## Operation
Opcodes:
- 1 HPY: heal.
- 2 DPY: damage.
- 3 IDG: invulnerability on.
- 4 SDG: invulnerability off.
- 5 MOV: move; operand[1:0] selects 0 up (Y−), 1 left (X−), 2 down (Y+), 3 right (X+).
- 6 SHP: set HP.
- 0 and 7–15: no-op.

Damage FSM states: IDLE, APPLY, IFRAME, DEAD.
- IDLE/IFRAME, `startDmg`=1 with opcode HPY or DPY: latch opcode and operand, go to APPLY. `startDmg` with any other opcode is ignored.
- APPLY, HPY: compute 9-bit sum hp+operand, saturate to HP_MAX.
- APPLY, DPY while `invuln`=1: HP unchanged.
- APPLY, DPY while `invuln`=0: if operand ≥ hp, hp=0; otherwise hp−operand.
- APPLY always pulses `dmgAck`, then branches:
  - hp becomes 0: go to DEAD.
  - DPY applied (not ignored): set `invuln`, load counter with IFRAMES, go to IFRAME.
  - otherwise: return to the prior state (IDLE or IFRAME).
- IFRAME: counter decrements each cycle; at 0, clear `invuln` (unless IDG is forcing it) and go to IDLE.
- DEAD: `isDeath`=1. `startDmg` and MOV are ignored. Only SHP with a nonzero operand leaves DEAD.

Word-change commands (SHP, IDG, SDG):
- `instrPrev` register; reset value 0.
- Executed once when `playerInstruction` ≠ `instrPrev` and the opcode is SHP, IDG or SDG. No strobe is needed.
- SHP: hp=min(operand, HP_MAX), position returns to INIT, iframe counter and the IDG force are cleared. Next state is IDLE, or DEAD if the operand is 0.
- IDG: forces `invuln`=1 until SDG.
- SDG: clears the force and the iframe counter; `invuln`=0; IFRAME goes to IDLE.

Move:
- Accepted when `isMove`=1, opcode is MOV, `moveCnt`=0 and state ≠ DEAD.
- Moves the position by STEP in the selected direction, clamped to [MIN, MAX] per axis.
- Reloads `moveCnt` with MOVE_DIV−1; `moveCnt` decrements to 0 each cycle.
- A held `isMove` therefore moves once every MOVE_DIV cycles.
- Runs independently of the damage FSM, including during APPLY.

Simultaneous events:
- A word-change SHP in the same cycle as `startDmg`: SHP wins; the strobe is dropped with no ack.
- `startDmg` while in APPLY is ignored.

## Timing
- Reset values: hp=HP_MAX, posX=X_INIT, posY=Y_INIT, isDeath=0, dmgAck=0, invuln=0. State IDLE, counters 0, `instrPrev`=0.
- Assertion of `rst_n` during APPLY aborts the request; no `dmgAck` is produced.
- All outputs are registered.
- `startDmg` sampled at edge t: hp, isDeath, invuln and dmgAck update at edge t+1. `dmgAck` is high for exactly one cycle.
- Move accepted at edge t: posX/posY update at edge t.
- Word-change commands: sampled and applied at the same edge; `instrPrev` updates every edge.
- IFRAME lasts IFRAMES cycles after the APPLY edge.

## Test plan
- Reset, then DPY 30 with `startDmg` → hp=70 one edge later, `dmgAck` pulse of 1 cycle, `invuln`=1 for 8 cycles.
- DPY 30 again during IFRAME → `dmgAck` pulses, hp stays 70.
- With `invuln` low: HPY 50 → hp=100 (saturated). Then DPY 120 → hp=0, `isDeath`=1.
- In DEAD: MOV and `startDmg` have no effect. SHP 100 (word change) → hp=100, `isDeath`=0, position=(320,360).
- Hold `isMove` with MOV right for 20 cycles → posX advances 2 every 4 cycles: 5 moves, 330. Moves toward the wall saturate at 420.
- IDG then DPY 50 → hp unchanged. SDG then DPY 50 → hp−50.
